// File: rtl/vga_ctrl_if.sv
// Pixel request bus between the VGA timing generator and a picture generator.
// The timing side (master) issues pic_x/pic_y/pic_req and receives pic_data
// one clock later from the registered picture generator (slave).
interface vga_ctrl_if;
    localparam int unsigned CW = 10;
    localparam int unsigned PW = 12;

    logic [CW-1:0] pic_x;
    logic [CW-1:0] pic_y;
    logic          pic_req;
    logic [PW-1:0] pic_data;

    modport master (
        output pic_x,
        output pic_y,
        output pic_req,
        input  pic_data
    );

    modport slave (
        input  pic_x,
        input  pic_y,
        input  pic_req,
        output pic_data
    );
endinterface

// File: rtl/vga_ctrl.sv
// VGA timing generator and pixel consumer.
// Runs the horizontal/vertical counters, decodes hsync/vsync, requests pixel
// coordinates one clock ahead of the active region, and gates the returned
// pic_data onto rgb. All outputs are decodes of the counter registers and rst.
module vga_ctrl #(
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BACK  = 48,
    parameter int unsigned H_VALID = 640,
    parameter int unsigned H_FRONT = 16,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BACK  = 33,
    parameter int unsigned V_VALID = 480,
    parameter int unsigned V_FRONT = 10
) (
    input  logic        vga_clk,
    input  logic        rst,
    vga_ctrl_if.master  pic,
    output logic        hsync,
    output logic        vsync,
    output logic        rgb_valid,
    output logic [11:0] rgb,
    output logic        frame_start,
    output logic [7:0]  frame_cnt
);
    localparam int unsigned CW      = 10;
    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int unsigned HA      = H_SYNC + H_BACK;
    localparam int unsigned VA      = V_SYNC + V_BACK;

    // Counter wrap points
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

    // Sync pulse ends
    localparam logic [CW-1:0] H_SYNC_C = CW'(H_SYNC);
    localparam logic [CW-1:0] V_SYNC_C = CW'(V_SYNC);

    // Active window (rgb side)
    localparam logic [CW-1:0] HA_BEG   = CW'(HA);
    localparam logic [CW-1:0] HA_END   = CW'(HA + H_VALID);
    localparam logic [CW-1:0] VA_BEG   = CW'(VA);
    localparam logic [CW-1:0] VA_END   = CW'(VA + V_VALID);

    // Request window, one clock ahead of the active window on the same line
    localparam logic [CW-1:0] HR_BEG   = CW'(HA - 1);
    localparam logic [CW-1:0] HR_END   = CW'(HA + H_VALID - 1);

    logic [CW-1:0] cnt_h;
    logic [CW-1:0] cnt_v;

    logic h_last;
    logic v_last;
    logic h_act;
    logic h_req;
    logic v_act;

    // Position decodes shared by the counters and the output logic
    always_comb begin
        h_last = 1'b0;
        v_last = 1'b0;
        h_act  = 1'b0;
        h_req  = 1'b0;
        v_act  = 1'b0;

        h_last = (cnt_h == H_LAST);
        v_last = (cnt_v == V_LAST);
        h_act  = (cnt_h >= HA_BEG) && (cnt_h < HA_END);
        h_req  = (cnt_h >= HR_BEG) && (cnt_h < HR_END);
        v_act  = (cnt_v >= VA_BEG) && (cnt_v < VA_END);
    end

    // Horizontal/vertical counters and completed-frame counter
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            cnt_h     <= '0;
            cnt_v     <= '0;
            frame_cnt <= '0;
        end else begin
            if (h_last) begin
                cnt_h <= '0;
            end else begin
                cnt_h <= cnt_h + CW'(1);
            end

            if (h_last) begin
                if (v_last) begin
                    cnt_v <= '0;
                end else begin
                    cnt_v <= cnt_v + CW'(1);
                end
            end

            if (h_last && v_last) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    // Output decode; reset forces the idle values regardless of counter state
    always_comb begin
        hsync       = 1'b1;
        vsync       = 1'b1;
        rgb_valid   = 1'b0;
        rgb         = 12'h000;
        frame_start = 1'b0;
        pic.pic_req = 1'b0;
        pic.pic_x   = '0;
        pic.pic_y   = '0;

        if (!rst) begin
            hsync       = (cnt_h >= H_SYNC_C);
            vsync       = (cnt_v >= V_SYNC_C);
            rgb_valid   = h_act && v_act;
            frame_start = (cnt_h == '0) && (cnt_v == '0);
            pic.pic_req = h_req && v_act;

            if (h_req && v_act) begin
                pic.pic_x = cnt_h - HR_BEG;
                pic.pic_y = cnt_v - VA_BEG;
            end

            // pic_data answers the previous cycle's request, which lands here
            if (h_act && v_act) begin
                rgb = pic.pic_data;
            end
        end
    end
endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl with a reduced timing set so that frame_cnt can wrap in
// a short run. Expected timing is derived from the cycle count since reset;
// pixel data goes through a request->rgb scoreboard.
module tb_vga_ctrl;
    localparam int unsigned H_SYNC  = 4;
    localparam int unsigned H_BACK  = 3;
    localparam int unsigned H_VALID = 10;
    localparam int unsigned H_FRONT = 3;
    localparam int unsigned V_SYNC  = 2;
    localparam int unsigned V_BACK  = 2;
    localparam int unsigned V_VALID = 4;
    localparam int unsigned V_FRONT = 2;
    localparam int unsigned HT = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int unsigned VT = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int unsigned FT = HT * VT;
    localparam int unsigned HA = H_SYNC + H_BACK;
    localparam int unsigned VA = V_SYNC + V_BACK;

    logic        clk;
    logic        rst;
    logic        hsync;
    logic        vsync;
    logic        rgb_valid;
    logic [11:0] rgb;
    logic        frame_start;
    logic [7:0]  frame_cnt;

    vga_ctrl_if pic_bus ();

    vga_ctrl #(
        .H_SYNC (H_SYNC),
        .H_BACK (H_BACK),
        .H_VALID(H_VALID),
        .H_FRONT(H_FRONT),
        .V_SYNC (V_SYNC),
        .V_BACK (V_BACK),
        .V_VALID(V_VALID),
        .V_FRONT(V_FRONT)
    ) dut (
        .vga_clk    (clk),
        .rst        (rst),
        .pic        (pic_bus),
        .hsync      (hsync),
        .vsync      (vsync),
        .rgb_valid  (rgb_valid),
        .rgb        (rgb),
        .frame_start(frame_start),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Registered picture generator: echoes the requested coordinates
    always @(posedge clk) begin
        pic_bus.pic_data <= {pic_bus.pic_y[5:0], pic_bus.pic_x[5:0]};
    end

    // Cycles since the last clock edge that saw rst high
    int unsigned t     = 0;
    bit          armed = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            t     <= 0;
            armed <= 1'b1;
        end else begin
            t <= t + 1;
        end
    end

    logic [11:0]  sb[$];
    int unsigned  vcount     = 0;
    bit           seen_frame = 1'b0;

    // Per-cycle timing checks and rgb scoreboard
    always @(negedge clk) begin
        int unsigned h, v, fc, ex, ey;
        bit e_act, e_req;
        logic [11:0] exp_rgb;
        if (armed) begin
            if (rst) begin
                check_eq("hsync_rst", 32'(hsync), 32'd1);
                check_eq("vsync_rst", 32'(vsync), 32'd1);
                check_eq("req_rst", 32'(pic_bus.pic_req), 32'd0);
                check_eq("x_rst", 32'(pic_bus.pic_x), 32'd0);
                check_eq("y_rst", 32'(pic_bus.pic_y), 32'd0);
                check_eq("valid_rst", 32'(rgb_valid), 32'd0);
                check_eq("rgb_rst", 32'(rgb), 32'd0);
                check_eq("fs_rst", 32'(frame_start), 32'd0);
                sb.delete();
                vcount     = 0;
                seen_frame = 1'b0;
            end else begin
                h  = t % HT;
                v  = (t / HT) % VT;
                fc = (t / FT) % 256;
                e_act = (h >= HA) && (h < HA + H_VALID) && (v >= VA) && (v < VA + V_VALID);
                e_req = (h >= HA - 1) && (h < HA + H_VALID - 1) && (v >= VA) && (v < VA + V_VALID);
                ex = e_req ? h - (HA - 1) : 0;
                ey = e_req ? v - VA : 0;

                check_eq("hsync", 32'(hsync), 32'(h >= H_SYNC));
                check_eq("vsync", 32'(vsync), 32'(v >= V_SYNC));
                check_eq("rgb_valid", 32'(rgb_valid), 32'(e_act));
                check_eq("pic_req", 32'(pic_bus.pic_req), 32'(e_req));
                check_eq("pic_x", 32'(pic_bus.pic_x), 32'(ex));
                check_eq("pic_y", 32'(pic_bus.pic_y), 32'(ey));
                check_eq("frame_start", 32'(frame_start), 32'((h == 0) && (v == 0)));
                check_eq("frame_cnt", 32'(frame_cnt), 32'(fc));

                if (rgb_valid) begin
                    if (sb.size() == 0) begin
                        check_eq("sb_empty", 32'(sb.size()), 32'd1);
                    end else begin
                        exp_rgb = sb.pop_front();
                        check_eq("rgb", 32'(rgb), 32'(exp_rgb));
                    end
                    vcount++;
                end else begin
                    check_eq("rgb_blank", 32'(rgb), 32'd0);
                end

                if (e_req) begin
                    sb.push_back({6'(ey), 6'(ex)});
                end

                if (frame_start) begin
                    if (seen_frame) begin
                        check_eq("valid_per_frame", vcount, H_VALID * V_VALID);
                    end
                    seen_frame = 1'b1;
                    vcount     = 0;
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1 check_eq("first_frame_start", 32'(frame_start), 32'd1);

        // Three full frames, then abort mid-active at line 5, column 11
        repeat (3 * FT + 5 * HT + 11) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1 check_eq("restart_frame_start", 32'(frame_start), 32'd1);
        check_eq("restart_frame_cnt", 32'(frame_cnt), 32'd0);

        // Enough frames for frame_cnt to wrap 255 -> 0
        repeat (256 * FT + 2 * FT) @(posedge clk);
        #1 check_eq("end_frame_cnt", 32'(frame_cnt), 32'd2);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
